// File: rtl/div_mod_pipe.sv
// div_mod_pipe: fully pipelined signed divider returning quotient and remainder
// together, one division per cycle, with truncated/floored rounding, divide-by-zero
// and overflow flags, and a valid/ready handshake. A stall freezes the whole pipe.
module div_mod_pipe #(
  parameter  int DIVIDEND_W = 32,
  parameter  int DIVISOR_W  = 16,
  localparam int Q_W        = DIVIDEND_W - DIVISOR_W + 1,
  localparam int LAT        = Q_W + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q_W-1:0]        quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic [Q_W-1:0]        final_output,
  output logic                  div_by_zero,
  output logic                  overflow
);

  // One restoring stage per quotient bit; LAT also counts the sign and output stages.
  localparam int DIV_STAGES = LAT - 2;
  // Partial remainders need one bit more than the dividend so that the magnitude
  // of the most negative dividend and |divisor| << Q_W both fit.
  localparam int RW = DIVIDEND_W + 1;

  localparam logic [Q_W-1:0]          Q_MIN   = {1'b1, {(Q_W-1){1'b0}}};
  localparam logic [Q_W-1:0]          Q_MAX   = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic [Q_W-1:0]          Q_LSB   = {{(Q_W-1){1'b0}}, 1'b1};
  localparam logic signed [Q_W+1:0]   Q_ONE   = {{(Q_W+1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                 valid;
    logic                 neg;
    logic                 dnd_neg;
    logic [DIVISOR_W-1:0] divisor;
    logic [1:0]           mode;
    logic                 dz;
    logic                 ovf;
  } meta_t;

  meta_t                meta    [DIV_STAGES+1];
  logic [RW-1:0]        rem     [DIV_STAGES+1];
  logic [Q_W-1:0]       quo     [DIV_STAGES+1];
  logic [DIVISOR_W-1:0] dvs     [DIV_STAGES];
  logic [RW-1:0]        trial   [DIV_STAGES];
  logic [RW-1:0]        rem_nxt [DIV_STAGES];
  logic [Q_W-1:0]       quo_nxt [DIV_STAGES];

  logic [DIVIDEND_W-1:0] dnd_abs;
  logic [DIVISOR_W-1:0]  dvs_abs;
  logic                  pre_ovf;

  meta_t                 sg_meta;
  logic signed [Q_W+1:0] sg_q;
  logic signed [RW-1:0]  sg_r;

  logic                  fix;
  logic signed [Q_W+1:0] q_fix;
  logic signed [RW-1:0]  r_fix;
  logic                  q_bad;
  logic [Q_W-1:0]        res_q;
  logic [DIVISOR_W-1:0]  res_r;
  logic [Q_W-1:0]        res_f;
  logic                  res_dz;
  logic                  res_ovf;

  assign in_ready = !(out_valid && !out_ready);

  // Operand magnitudes and the early overflow test for quotients of Q_W+1 bits or more.
  always_comb begin
    dnd_abs = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    dvs_abs = divisor[DIVISOR_W-1] ? -divisor : divisor;
    pre_ovf = {1'b0, dnd_abs} >= {dvs_abs, {Q_W{1'b0}}};
  end

  // Each restoring stage tries to subtract the divisor aligned to its quotient bit.
  always_comb begin
    for (int j = 0; j < DIV_STAGES; j++) begin
      trial[j] = RW'(dvs[j]) << (Q_W - 1 - j);
      if (rem[j] >= trial[j]) begin
        rem_nxt[j] = rem[j] - trial[j];
        quo_nxt[j] = quo[j] | (Q_LSB << (Q_W - 1 - j));
      end else begin
        rem_nxt[j] = rem[j];
        quo_nxt[j] = quo[j];
      end
    end
  end

  // Floored correction, range check, saturation and the mode-selected result view.
  always_comb begin
    fix     = sg_meta.mode[1] && (sg_r != '0) &&
              (sg_meta.dnd_neg != sg_meta.divisor[DIVISOR_W-1]);
    q_fix   = fix ? (sg_q - Q_ONE) : sg_q;
    r_fix   = fix ? (sg_r + RW'($signed(sg_meta.divisor))) : sg_r;
    q_bad   = (q_fix[Q_W+1:Q_W-1] != 3'b000) && (q_fix[Q_W+1:Q_W-1] != 3'b111);
    res_q   = q_fix[Q_W-1:0];
    res_r   = DIVISOR_W'(r_fix);
    res_dz  = 1'b0;
    res_ovf = sg_meta.ovf || q_bad;
    if (sg_meta.dz) begin
      res_q   = '0;
      res_r   = '0;
      res_dz  = 1'b1;
      res_ovf = 1'b0;
    end else if (res_ovf) begin
      res_q = sg_meta.neg ? Q_MIN : Q_MAX;
      res_r = '0;
    end
    res_f = sg_meta.mode[0] ? res_q : Q_W'($signed(res_r));
    if (!sg_meta.valid) begin
      res_q   = '0;
      res_r   = '0;
      res_f   = '0;
      res_dz  = 1'b0;
      res_ovf = 1'b0;
    end
  end

  // Whole pipeline advances together when the output is not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j <= DIV_STAGES; j++) meta[j].valid <= 1'b0;
      sg_meta.valid <= 1'b0;
      out_valid     <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      final_output  <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
    end else if (in_ready) begin
      meta[0] <= '{valid:   in_valid,
                   neg:     dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1],
                   dnd_neg: dividend[DIVIDEND_W-1],
                   divisor: divisor,
                   mode:    mode,
                   dz:      (divisor == '0),
                   ovf:     pre_ovf};
      rem[0] <= {1'b0, dnd_abs};
      quo[0] <= '0;
      dvs[0] <= dvs_abs;
      for (int j = 0; j < DIV_STAGES; j++) begin
        meta[j+1] <= meta[j];
        rem[j+1]  <= rem_nxt[j];
        quo[j+1]  <= quo_nxt[j];
      end
      for (int j = 0; j < DIV_STAGES - 1; j++) dvs[j+1] <= dvs[j];
      sg_meta <= meta[DIV_STAGES];
      sg_q    <= meta[DIV_STAGES].neg ? -$signed({2'b00, quo[DIV_STAGES]})
                                      :  $signed({2'b00, quo[DIV_STAGES]});
      sg_r    <= meta[DIV_STAGES].dnd_neg ? -$signed(rem[DIV_STAGES])
                                          :  $signed(rem[DIV_STAGES]);
      out_valid    <= sg_meta.valid;
      quotient     <= res_q;
      remainder    <= res_r;
      final_output <= res_f;
      div_by_zero  <= res_dz;
      overflow     <= res_ovf;
    end
  end

endmodule

// File: tb/tb_div_mod_pipe.sv
// tb_div_mod_pipe: self-checking bench for div_mod_pipe at default widths plus a
// 16/8 instance, using directed cases and randomized traffic with back-pressure.
module tb_div_mod_pipe;

  localparam int DW    = 32;
  localparam int VW    = 16;
  localparam int QW    = DW - VW + 1;
  localparam int LAT   = QW + 2;
  localparam int S_LAT = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [QW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic [QW-1:0] final_output;
  logic          div_by_zero;
  logic          overflow;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [15:0]   s_dividend = '0;
  logic [7:0]    s_divisor = '0;
  logic [1:0]    s_mode = 2'b00;
  logic          s_out_valid;
  logic          s_out_ready = 1'b1;
  logic [8:0]    s_quotient;
  logic [7:0]    s_remainder;
  logic [8:0]    s_final;
  logic          s_dz;
  logic          s_ov;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    longint q;
    longint r;
    logic   dz;
    logic   ov;
  } res_t;

  typedef struct packed {
    logic [QW-1:0] q;
    logic [VW-1:0] r;
    logic [QW-1:0] f;
    logic          dz;
    logic          ov;
  } exp_t;

  div_mod_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .final_output(final_output),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  div_mod_pipe #(.DIVIDEND_W(16), .DIVISOR_W(8)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .dividend(s_dividend), .divisor(s_divisor), .mode(s_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .quotient(s_quotient),
    .remainder(s_remainder), .final_output(s_final),
    .div_by_zero(s_dz), .overflow(s_ov)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: exact integer division, floor variant, then saturation on overflow.
  function automatic res_t ref_div(input longint a, input longint b, input bit floored, input int qw);
    res_t   o;
    longint qmax;
    longint qmin;
    qmax = (longint'(1) << (qw - 1)) - 1;
    qmin = -(longint'(1) << (qw - 1));
    o = '0;
    if (b == 0) begin
      o.dz = 1'b1;
      return o;
    end
    o.q = a / b;
    if (floored && (a % b != 0) && ((a < 0) != (b < 0))) o.q = o.q - 1;
    o.r = a - o.q * b;
    if (o.q > qmax || o.q < qmin) begin
      o.ov = 1'b1;
      o.q  = (o.q > 0) ? qmax : qmin;
      o.r  = 0;
    end
    return o;
  endfunction

  task automatic test_reset();
    int seen;
    reset = 1'b1; in_valid = 1'b1; dividend = 32'd77; divisor = 16'd3; mode = 2'b01;
    s_in_valid = 1'b1; s_dividend = 16'd5; s_divisor = 8'd2; s_mode = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if ({quotient, remainder, final_output} !== '0) begin errors++; $display("[TB] FAIL reset_data: got q=%0d r=%0d f=%0d expected 0", quotient, remainder, final_output); end
    checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b%b expected 00", div_by_zero, overflow); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_small_valid: got %b expected 0", s_out_valid); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid || s_out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL reset_ignored_transfer: got %0d results expected 0", seen); end
  endtask

  task automatic test_basic_latency();
    int lat;
    @(negedge clk);
    out_ready = 1'b1; dividend = 32'd100; divisor = 16'd7; mode = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    checks++; if ($signed(quotient) !== 14) begin errors++; $display("[TB] FAIL basic_q: got %0d expected 14", $signed(quotient)); end
    checks++; if ($signed(remainder) !== 2) begin errors++; $display("[TB] FAIL basic_r: got %0d expected 2", $signed(remainder)); end
    checks++; if ($signed(final_output) !== 14) begin errors++; $display("[TB] FAIL basic_final: got %0d expected 14", $signed(final_output)); end
    checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL basic_flags: got %b%b expected 00", div_by_zero, overflow); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_single: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_signed_modes();
    logic [1:0] modes [3];
    int eq [3];
    int er [3];
    int ef [3];
    int n;
    modes = '{2'b01, 2'b11, 2'b10};
    eq = '{-14, -15, -15};
    er = '{-2, 5, 5};
    ef = '{-14, -15, 5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dividend = -32'sd100; divisor = 16'd7; mode = modes[i]; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; mode = 2'b00;
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL modes_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if ($signed(quotient) !== eq[i]) begin errors++; $display("[TB] FAIL modes_q[%0d]: got %0d expected %0d", i, $signed(quotient), eq[i]); end
      checks++; if ($signed(remainder) !== er[i]) begin errors++; $display("[TB] FAIL modes_r[%0d]: got %0d expected %0d", i, $signed(remainder), er[i]); end
      checks++; if ($signed(final_output) !== ef[i]) begin errors++; $display("[TB] FAIL modes_final[%0d]: got %0d expected %0d", i, $signed(final_output), ef[i]); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL modes_tail: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_corner();
    logic [DW-1:0] a  [4];
    logic [VW-1:0] b  [4];
    int            eq [4];
    logic          edz [4];
    logic          eov [4];
    int n;
    a   = '{32'd1234, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    b   = '{16'd0, 16'd1, 16'hFFFF, 16'd1};
    eq  = '{0, 65535, 65535, -65536};
    edz = '{1'b1, 1'b0, 1'b0, 1'b0};
    eov = '{1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dividend = a[i]; divisor = b[i]; mode = 2'b01; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL corner_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if ($signed(quotient) !== eq[i]) begin errors++; $display("[TB] FAIL corner_q[%0d]: got %0d expected %0d", i, $signed(quotient), eq[i]); end
      checks++; if (remainder !== '0) begin errors++; $display("[TB] FAIL corner_r[%0d]: got %0d expected 0", i, $signed(remainder)); end
      checks++; if ($signed(final_output) !== eq[i]) begin errors++; $display("[TB] FAIL corner_final[%0d]: got %0d expected %0d", i, $signed(final_output), eq[i]); end
      checks++; if ({div_by_zero, overflow} !== {edz[i], eov[i]}) begin errors++; $display("[TB] FAIL corner_flags[%0d]: got %b%b expected %b%b", i, div_by_zero, overflow, edz[i], eov[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_backpressure();
    exp_t       sb [$];
    exp_t       e;
    exp_t       got;
    exp_t       held;
    res_t       o;
    bit         stall_prev;
    bit         accepted;
    int         sent;
    int         rcvd;
    int         cyc;
    int         extra;
    logic [31:0] ra;
    logic [15:0] rb;
    logic [1:0]  rm;
    stall_prev = 1'b0; accepted = 1'b0; sent = 0; rcvd = 0; cyc = 0;
    held = '0;
    in_valid = 1'b0;
    while (rcvd < 40 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (accepted) begin in_valid = 1'b0; accepted = 1'b0; end
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 40) begin
        ra = $urandom;
        ra = $signed(ra) >>> $urandom_range(0, 31);
        rb = 16'($urandom);
        rb = $signed(rb) >>> $urandom_range(0, 15);
        if ($urandom_range(0, 9) == 0) rb = '0;
        rm = 2'($urandom_range(0, 3));
        dividend = ra; divisor = rb; mode = rm; in_valid = 1'b1;
      end
      #1;
      got = '{q: quotient, r: remainder, f: final_output, dz: div_by_zero, ov: overflow};
      if (stall_prev) begin
        checks++;
        if (!out_valid || got !== held) begin errors++; $display("[TB] FAIL rand_stall_hold: got v=%b %h expected v=1 %h", out_valid, got, held); end
      end
      if (!out_valid) begin
        checks++;
        if (got !== '0) begin errors++; $display("[TB] FAIL rand_idle_zero: got %h expected 0", got); end
      end else if (out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra_result: got %h expected none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("[TB] FAIL rand_result[%0d]: got q=%0d r=%0d f=%0d dz=%b ov=%b expected q=%0d r=%0d f=%0d dz=%b ov=%b",
                     rcvd, $signed(got.q), $signed(got.r), $signed(got.f), got.dz, got.ov,
                     $signed(e.q), $signed(e.r), $signed(e.f), e.dz, e.ov);
          end
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        o = ref_div(longint'($signed(dividend)), longint'($signed(divisor)), mode[1], QW);
        e.q  = o.q[QW-1:0];
        e.r  = o.r[VW-1:0];
        e.f  = mode[0] ? o.q[QW-1:0] : o.r[QW-1:0];
        e.dz = o.dz;
        e.ov = o.ov;
        sb.push_back(e);
        sent++;
        accepted = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      held = got;
    end
    checks++;
    if (rcvd != 40) begin errors++; $display("[TB] FAIL rand_timeout: got %0d results expected 40", rcvd); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) extra++; end
    checks++;
    if (extra != 0 || sb.size() != 0) begin errors++; $display("[TB] FAIL rand_drain: got %0d extra, %0d pending expected 0, 0", extra, sb.size()); end
  endtask

  task automatic test_reset_flush();
    int lat;
    int ghosts;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dividend = 32'($urandom_range(0, 100000)); divisor = 16'($urandom_range(1, 300));
      mode = 2'b01; in_valid = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1; dividend = 32'd55; divisor = 16'd5; in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    dividend = 32'd1000; divisor = -16'sd9; mode = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL flush_latency: got %0d expected %0d", lat, LAT); end
    checks++; if ($signed(quotient) !== -111) begin errors++; $display("[TB] FAIL flush_q: got %0d expected -111", $signed(quotient)); end
    checks++; if ($signed(remainder) !== 1) begin errors++; $display("[TB] FAIL flush_r: got %0d expected 1", $signed(remainder)); end
    ghosts = 0;
    repeat (25) begin @(posedge clk); #1; if (out_valid) ghosts++; end
    checks++; if (ghosts != 0) begin errors++; $display("[TB] FAIL flush_ghosts: got %0d results expected 0", ghosts); end
  endtask

  task automatic test_small_config();
    int lat;
    @(negedge clk);
    s_out_ready = 1'b1; s_dividend = -16'sd128; s_divisor = 8'd3; s_mode = 2'b01; s_in_valid = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL small_in_ready: got %b expected 1", s_in_ready); end
    @(posedge clk); #1;
    s_mode = 2'b11;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != S_LAT) begin errors++; $display("[TB] FAIL small_latency: got %0d expected %0d", lat, S_LAT); end
    checks++; if ($signed(s_quotient) !== -42) begin errors++; $display("[TB] FAIL small_trunc_q: got %0d expected -42", $signed(s_quotient)); end
    checks++; if ($signed(s_remainder) !== -2) begin errors++; $display("[TB] FAIL small_trunc_r: got %0d expected -2", $signed(s_remainder)); end
    checks++; if ($signed(s_final) !== -42) begin errors++; $display("[TB] FAIL small_trunc_final: got %0d expected -42", $signed(s_final)); end
    @(posedge clk); #1;
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL small_floor_valid: got %b expected 1", s_out_valid); end
    checks++; if ($signed(s_quotient) !== -43) begin errors++; $display("[TB] FAIL small_floor_q: got %0d expected -43", $signed(s_quotient)); end
    checks++; if ($signed(s_remainder) !== 1) begin errors++; $display("[TB] FAIL small_floor_r: got %0d expected 1", $signed(s_remainder)); end
    checks++; if ({s_dz, s_ov} !== 2'b00) begin errors++; $display("[TB] FAIL small_flags: got %b%b expected 00", s_dz, s_ov); end
  endtask

  initial begin
    $display("[TB] div_mod_pipe bench start");
    test_reset();
    test_basic_latency();
    test_signed_modes();
    test_corner();
    test_random_backpressure();
    test_reset_flush();
    test_small_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_mod_pipe.md
# div_mod_pipe

Parametrised, fully pipelined signed divider producing quotient and remainder together, one division per cycle. Adds truncated and floored rounding modes, divide-by-zero and overflow flags, and a valid/ready handshake with back-pressure. Sits where the fixed 32/16-bit divide/modulo top level sits and replaces it in new datapaths. `final_output` keeps the mode-selected single-result view used by existing consumers.

## Interface
- DIVIDEND_W, 32, dividend width in bits, signed two's complement; must be greater than DIVISOR_W.
- DIVISOR_W, 16, divisor and remainder width, signed; must be at least 2.
- Q_W (derived, not overridable) = DIVIDEND_W − DIVISOR_W + 1; quotient and `final_output` width.
- LAT (derived) = Q_W + 2; pipeline depth in cycles.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept this cycle.
- dividend  in  DIVIDEND_W  signed dividend.
- divisor  in  DIVISOR_W  signed divisor.
- mode  in  2  bit0: 1 = final_output is quotient, 0 = remainder; bit1: 1 = floored, 0 = truncated.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  Q_W  signed quotient.
- remainder  out  DIVISOR_W  signed remainder.
- final_output  out  Q_W  quotient or sign-extended remainder, selected by the transaction's mode bit0.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  exact quotient not representable in Q_W bits.

## Operation
- Handshake: a transfer occurs when `in_valid && in_ready`. A result is delivered when `out_valid && out_ready`.
- `in_ready = !(out_valid && !out_ready)`. On a stall the whole pipeline holds; no bubbles are squeezed out.
- Input stage:
  - Registers the absolute values of both operands, the result sign (dividend sign XOR divisor sign), the dividend sign, the divisor, mode and a valid bit.
  - Pre-check: overflow magnitude if |dividend| ≥ |divisor| << Q_W.
- Q_W stages: restoring division; each stage resolves one quotient bit, MSB first, on unsigned magnitudes. mode, flags, signs and valid travel with the data.
- Output stage:
  - Apply signs. The truncated remainder takes the dividend's sign.
  - If floored, the remainder is nonzero, and its sign differs from the divisor's: quotient −= 1, remainder += divisor.
  - Register all outputs.
- Overflow is set when either:
  - the signed quotient (after any floored correction) lies outside [−2^(Q_W−1), 2^(Q_W−1)−1], or
  - the pre-check fired.
  - On overflow: quotient saturates to 2^(Q_W−1)−1 for a positive result or −2^(Q_W−1) for a negative one; remainder = 0.
- Divide by zero: div_by_zero = 1, overflow = 0, quotient = 0, remainder = 0. div_by_zero takes priority over overflow.
- Outputs are held stable while `out_valid && !out_ready`. When `out_valid = 0`, final_output, quotient, remainder and both flags are 0.

## Timing
- Reset: every pipeline valid bit clears. Outputs reset to out_valid = 0, quotient = 0, remainder = 0, final_output = 0, div_by_zero = 0, overflow = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded, none is emitted. A transfer attempted in the reset cycle is ignored.
- Latency: a transfer accepted at edge k yields out_valid at edge k + LAT with no stalls (LAT = 19 at defaults). Each stall cycle adds exactly one cycle.
- Throughput: one transfer per cycle with out_ready held high.
- Simultaneous input and output transfers in the same cycle are legal and lossless.
- Results leave in acceptance order. Each result carries its own mode; changing mode between transfers never affects in-flight results.

## Test plan
- 100 / 7, mode 01 → quotient 14, remainder 2, final_output 14, flags 0, out_valid exactly 19 cycles after acceptance.
- −100 / 7: mode 01 → q −14, r −2. Mode 11 → q −15, r 5. Mode 10 → final_output 5. Issue back-to-back, one per cycle; results must arrive on consecutive cycles.
- 1234 / 0 → div_by_zero 1, q 0, r 0. 0x7FFFFFFF / 1 → overflow 1, q 65535, r 0. −2^31 / −1 → overflow 1, q 65535. −2^31 / 1 → overflow 1, q −65536.
- Fill the pipe with 40 random operand pairs while toggling out_ready at 50 %. Every result must match a reference model in order; outputs must be stable during stalls; none lost or duplicated.
- Reset asserted for 1 cycle with 10 transactions in flight → no out_valid afterwards. A new transfer 1 cycle later completes correctly after 19 cycles.
- Rebuild with DIVIDEND_W = 16, DIVISOR_W = 8 (Q_W = 9, LAT = 11): −128 / 3 truncated → q −42, r −2; floored → q −43, r 1.
